// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared widths, FSM encoding and fetch payload type for the instruction fetch sequencer.
package imem_fetch_ctrl_pkg;

  localparam int unsigned WORD_LENGTH   = 16;
  localparam int unsigned ADDRESS_SPACE = 21;

  localparam logic [ADDRESS_SPACE-1:0] RESET_VEC_DEFAULT = ADDRESS_SPACE'(0);
  localparam logic [ADDRESS_SPACE-1:0] INT_VEC_DEFAULT   = ADDRESS_SPACE'(2);

  typedef enum logic [1:0] {
    ST_VEC_HI = 2'd0,
    ST_VEC_LO = 2'd1,
    ST_VEC_WB = 2'd2,
    ST_FETCH  = 2'd3
  } fetch_state_t;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [WORD_LENGTH-1:0]   data;
    logic [ADDRESS_SPACE-1:0] pc;
  } fetch_word_t;

  // Build a PC from the high/low vector words; bits above the address width are dropped.
  function automatic logic [ADDRESS_SPACE-1:0] vec_join(
    input logic [WORD_LENGTH-1:0] hi,
    input logic [WORD_LENGTH-1:0] lo
  );
    return ADDRESS_SPACE'({hi, lo});
  endfunction

endpackage

// File: rtl/imem_fetch_ctrl_skid_buf.sv
// Single-entry hold register that keeps a fetched word alive while IF/ID is stalled.
module imem_fetch_ctrl_skid_buf
  import imem_fetch_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        capture,
  input  logic        drain,
  input  logic        flush,
  input  fetch_word_t din,
  output fetch_word_t dout,
  output logic        valid
);

  // Flush beats capture beats drain; payload only loads on capture.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (capture) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: vector load, sequential fetch, stall hold, redirect and interrupt entry.
module imem_fetch_ctrl
  import imem_fetch_ctrl_pkg::*;
#(
  parameter logic [ADDRESS_SPACE-1:0] RESET_VEC_ADDR = RESET_VEC_DEFAULT,
  parameter logic [ADDRESS_SPACE-1:0] INT_VEC_ADDR   = INT_VEC_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [ADDRESS_SPACE-1:0] mem_addr,
  output logic                     mem_en,
  input  logic [WORD_LENGTH-1:0]   mem_data,
  input  logic                     stall,
  input  logic                     redirect,
  input  logic [ADDRESS_SPACE-1:0] redirect_pc,
  input  logic                     int_req,
  output logic                     int_ack,
  output logic [ADDRESS_SPACE-1:0] int_ret_pc,
  output logic [WORD_LENGTH-1:0]   instr,
  output logic [ADDRESS_SPACE-1:0] instr_pc,
  output logic                     instr_valid
);

  fetch_state_t             state, state_nxt;
  logic [ADDRESS_SPACE-1:0] vec_base, vec_base_nxt;
  logic [ADDRESS_SPACE-1:0] pc, pc_nxt;
  logic [WORD_LENGTH-1:0]   vec_hi, vec_hi_nxt;
  logic                     inflight, inflight_nxt;
  logic [ADDRESS_SPACE-1:0] inflight_pc, inflight_pc_nxt;
  logic                     int_ack_nxt;
  logic [ADDRESS_SPACE-1:0] int_ret_pc_nxt;

  logic        hold_capture, hold_drain, hold_flush;
  logic        hold_valid;
  logic        out_kill;
  fetch_word_t hold;
  fetch_word_t hold_din;

  assign hold_din.data = mem_data;
  assign hold_din.pc   = inflight_pc;

  imem_fetch_ctrl_skid_buf u_skid (
    .clk     (clk),
    .reset   (reset),
    .capture (hold_capture),
    .drain   (hold_drain),
    .flush   (hold_flush),
    .din     (hold_din),
    .dout    (hold),
    .valid   (hold_valid)
  );

  // State and datapath registers; synchronous reset restarts the reset-vector load.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_VEC_HI;
      vec_base    <= RESET_VEC_ADDR;
      pc          <= '0;
      vec_hi      <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      int_ack     <= 1'b0;
      int_ret_pc  <= '0;
    end else begin
      state       <= state_nxt;
      vec_base    <= vec_base_nxt;
      pc          <= pc_nxt;
      vec_hi      <= vec_hi_nxt;
      inflight    <= inflight_nxt;
      inflight_pc <= inflight_pc_nxt;
      int_ack     <= int_ack_nxt;
      int_ret_pc  <= int_ret_pc_nxt;
    end
  end

  // Next-state, memory request and hold control; redirect outranks interrupt outranks normal fetch.
  always_comb begin
    state_nxt       = state;
    vec_base_nxt    = vec_base;
    pc_nxt          = pc;
    vec_hi_nxt      = vec_hi;
    inflight_nxt    = 1'b0;
    inflight_pc_nxt = inflight_pc;
    int_ack_nxt     = 1'b0;
    int_ret_pc_nxt  = int_ret_pc;
    mem_en          = 1'b0;
    mem_addr        = pc;
    hold_capture    = 1'b0;
    hold_drain      = 1'b0;
    hold_flush      = 1'b0;
    out_kill        = 1'b0;

    unique case (state)
      ST_VEC_HI: begin
        mem_en    = 1'b1;
        mem_addr  = vec_base;
        state_nxt = ST_VEC_LO;
      end
      ST_VEC_LO: begin
        mem_en     = 1'b1;
        mem_addr   = vec_base + ADDRESS_SPACE'(1);
        vec_hi_nxt = mem_data;
        state_nxt  = ST_VEC_WB;
      end
      ST_VEC_WB: begin
        pc_nxt    = vec_join(vec_hi, mem_data);
        state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (redirect) begin
          pc_nxt     = redirect_pc;
          hold_flush = 1'b1;
          out_kill   = 1'b1;
        end else if (int_req && !stall) begin
          // Whatever is presented this cycle is squashed, so the return PC is the oldest unconsumed one.
          int_ack_nxt    = 1'b1;
          int_ret_pc_nxt = hold_valid ? hold.pc : (inflight ? inflight_pc : pc);
          hold_flush     = 1'b1;
          out_kill       = 1'b1;
          vec_base_nxt   = INT_VEC_ADDR;
          state_nxt      = ST_VEC_HI;
        end else if (stall) begin
          hold_capture = inflight && !hold_valid;
        end else if (hold_valid) begin
          hold_drain = 1'b1;
        end else begin
          mem_en          = 1'b1;
          mem_addr        = pc;
          pc_nxt          = pc + ADDRESS_SPACE'(1);
          inflight_nxt    = 1'b1;
          inflight_pc_nxt = pc;
        end
      end
      default: begin
        state_nxt = ST_VEC_HI;
      end
    endcase
  end

  // Output mux: held word has precedence over the word arriving from memory.
  always_comb begin
    instr       = hold_valid ? hold.data : mem_data;
    instr_pc    = hold_valid ? hold.pc   : inflight_pc;
    instr_valid = (state == ST_FETCH) && !out_kill && (hold_valid || inflight);
  end

endmodule
